// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if -- data-memory request/response bus.
//
// Signals:
//   mem_req    request valid (held until mem_ack)
//   mem_we     request is a write
//   mem_addr   request address
//   mem_wdata  store data
//   mem_ack    completion strobe from memory
//   mem_rdata  load data, valid with mem_ack
//
// Modports:
//   master  the pipeline stage issuing requests
//   slave   the data memory answering them
interface mem_access_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_ack, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage -- pipeline memory-access stage.
//
// ALU results pass straight to the writeback registers one cycle after
// valid_in. Loads and stores capture their operands, raise stall and wait in
// REQ holding the memory request stable until mem_ack; writeback follows one
// cycle after the ack. A combined read+write is performed as a write.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_in            execute-stage result valid
//   regDdata, regBdata  ALU result (memory address) and store data
//   zero, PCNEXT        ALU zero flag and branch target
//   regD                destination register index
//   mem_read, mem_write, branch, reg_write   control flags
//   mem                 data-memory bus (master side)
//   stall               upstream must hold its inputs
//   wb_valid, wb_data, wb_regD, wb_reg_write writeback outputs
//   pc_src, branch_target                    branch decision
//   misalign            alignment fault flag
//
// Build option MEM_ALIGN_CHECK_EN: when defined, a load/store whose address
// has nonzero low bits issues no request and completes next cycle with
// misalign=1 and no register write. When undefined, the low two address bits
// are cleared on the bus and misalign is tied low.
module mem_access_stage (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_in,
   input  logic [31:0]         regDdata,
   input  logic [31:0]         regBdata,
   input  logic                zero,
   input  logic [31:0]         PCNEXT,
   input  logic [4:0]          regD,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic                branch,
   input  logic                reg_write,
   mem_access_stage_if.master  mem,
   output logic                stall,
   output logic                wb_valid,
   output logic [31:0]         wb_data,
   output logic [4:0]          wb_regD,
   output logic                wb_reg_write,
   output logic                pc_src,
   output logic [31:0]         branch_target,
   output logic                misalign
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   logic [0:0]  state;
   logic        mem_op;
   logic        accept;
   logic        misalign_hit;

   logic [31:0] addr_p1;
   logic [31:0] wdata_p1;
   logic [31:0] pcnext_p1;
   logic [4:0]  regd_p1;
   logic        we_p1;
   logic        regwr_p1;
   logic        pcsrc_p1;

   always_comb begin
      mem_op = mem_read | mem_write;
      accept = (state == IDLE) && valid_in;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_hit = accept && mem_op && (regDdata[1:0] != 2'b00);
`else
      misalign_hit = 1'b0;
`endif
      // Stall asserts in the accept cycle itself so upstream holds this op.
      stall = !reset && ((state == REQ) || (accept && mem_op && !misalign_hit));
   end

   // Stage p1: operands of an accepted memory operation, held through REQ
   always_ff @(posedge clk) begin
      if (accept && mem_op) begin
         addr_p1   <= regDdata;
         wdata_p1  <= regBdata;
         pcnext_p1 <= PCNEXT;
         regd_p1   <= regD;
         we_p1     <= mem_write;
         regwr_p1  <= reg_write;
         pcsrc_p1  <= branch & zero;
      end
   end

   assign mem.mem_req   = (state == REQ);
   assign mem.mem_we    = we_p1;
   assign mem.mem_wdata = wdata_p1;

   // Stage p2: FSM and writeback registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         wb_valid      <= 1'b0;
         wb_data       <= 32'd0;
         wb_regD       <= 5'd0;
         wb_reg_write  <= 1'b0;
         pc_src        <= 1'b0;
         branch_target <= 32'd0;
      end else begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         pc_src       <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  if (mem_op && !misalign_hit) begin
                     state <= REQ;
                  end else begin
                     wb_valid      <= 1'b1;
                     wb_data       <= regDdata;
                     wb_regD       <= regD;
                     wb_reg_write  <= reg_write && !misalign_hit;
                     pc_src        <= branch & zero;
                     branch_target <= PCNEXT;
                  end
               end
            end
            REQ: begin
               if (mem.mem_ack) begin
                  state         <= IDLE;
                  wb_valid      <= 1'b1;
                  // A store reports its address; read data is ignored.
                  wb_data       <= we_p1 ? addr_p1 : mem.mem_rdata;
                  wb_regD       <= regd_p1;
                  wb_reg_write  <= regwr_p1;
                  pc_src        <= pcsrc_p1;
                  branch_target <= pcnext_p1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign_hit;
   end

   assign misalign     = misalign_q;
   assign mem.mem_addr = addr_p1;
`else
   assign misalign     = 1'b0;
   assign mem.mem_addr = {addr_p1[31:2], 2'b00};
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage -- self-checking bench for mem_access_stage.
// Expected behaviour is kept as per-cycle expectation tables filled by the
// stimulus tasks; one negedge process compares the DUT against them.
module tb_mem_access_stage;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] regDdata, regBdata, PCNEXT;
   logic        zero, mem_read, mem_write, branch, reg_write;
   logic [4:0]  regD;
   logic        stall, wb_valid, wb_reg_write, pc_src, misalign;
   logic [31:0] wb_data, branch_target;
   logic [4:0]  wb_regD;

   mem_access_stage_if mem_bus ();

   mem_access_stage dut (
      .clk(clk), .reset(reset), .valid_in(valid_in),
      .regDdata(regDdata), .regBdata(regBdata), .zero(zero), .PCNEXT(PCNEXT),
      .regD(regD), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .reg_write(reg_write), .mem(mem_bus),
      .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
      .wb_regD(wb_regD), .wb_reg_write(wb_reg_write), .pc_src(pc_src),
      .branch_target(branch_target), .misalign(misalign)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] tgt;
      logic [4:0]  regd;
      logic        rw;
      logic        pcs;
      logic        mis;
      logic        chk_data;
   } wb_t;

   bit          exp_stall [int];
   bit          exp_req   [int];
   logic [31:0] exp_addr  [int];
   logic [31:0] exp_wdata [int];
   bit          exp_we    [int];
   wb_t         exp_wb    [int];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Compare process
   int  c;
   bit  er;
   wb_t w;
   always @(negedge clk) begin
      if (chk_en) begin
         c = cyc;
         if (!reset) chk("stall", stall, (exp_stall.exists(c) && exp_stall[c]) ? 1 : 0);
         er = exp_req.exists(c) && exp_req[c];
         chk("mem_req", mem_bus.mem_req, er);
         if (er) begin
            chk("mem_addr", mem_bus.mem_addr, exp_addr[c]);
            chk("mem_we", mem_bus.mem_we, exp_we[c]);
            if (exp_we[c]) chk("mem_wdata", mem_bus.mem_wdata, exp_wdata[c]);
         end
         if (exp_wb.exists(c)) begin
            w = exp_wb[c];
            chk("wb_valid", wb_valid, 1);
            chk("wb_reg_write", wb_reg_write, w.rw);
            chk("pc_src", pc_src, w.pcs);
            chk("misalign", misalign, w.mis);
            chk("wb_regD", wb_regD, w.regd);
            chk("branch_target", branch_target, w.tgt);
            if (w.chk_data) chk("wb_data", wb_data, w.data);
         end else begin
            chk("wb_valid_idle", wb_valid, 0);
            chk("wb_reg_write_idle", wb_reg_write, 0);
            chk("pc_src_idle", pc_src, 0);
            chk("misalign_idle", misalign, 0);
         end
      end
   end

   task automatic junk_inputs();
      regDdata  = $urandom;
      regBdata  = $urandom;
      PCNEXT    = $urandom;
      regD      = 5'($urandom_range(0, 31));
      zero      = 1'($urandom_range(0, 1));
      branch    = 1'($urandom_range(0, 1));
      reg_write = 1'($urandom_range(0, 1));
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = 1'($urandom_range(0, 1));
      mem_bus.mem_rdata = $urandom;
   endtask

   task automatic idle_inputs();
      junk_inputs();
      valid_in        = 1'b0;
      mem_bus.mem_ack = 1'($urandom_range(0, 1));
   endtask

   task automatic gap(input int m);
      for (int i = 0; i < m; i++) begin
         idle_inputs();
         @(posedge clk); #1;
      end
   endtask

   // Called #1 after a posedge; returns #1 after the posedge that starts the
   // writeback cycle of this operation.
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] ridx,
                        input bit rw, input bit br, input bit z,
                        input logic [31:0] pcn, input logic [31:0] rdata,
                        input int waits);
      int  n;
      bit  memop, mis;
      n     = cyc;
      memop = rd | wr;
      mis   = ALIGN_EN && memop && (addr[1:0] != 2'b00);
      valid_in = 1'b1; regDdata = addr; regBdata = wd; regD = ridx;
      mem_read = rd; mem_write = wr; branch = br; zero = z; PCNEXT = pcn;
      reg_write = rw;
      mem_bus.mem_ack   = 1'($urandom_range(0, 1));
      mem_bus.mem_rdata = $urandom;
      exp_stall[n] = memop && !mis;
      if (!memop || mis) begin
         exp_wb[n+1] = '{data: addr, tgt: pcn, regd: ridx, rw: rw && !mis,
                         pcs: br & z, mis: mis, chk_data: !mis};
         @(posedge clk); #1;
      end else begin
         for (int k = 0; k <= waits; k++) begin
            exp_req[n+1+k]   = 1'b1;
            exp_stall[n+1+k] = 1'b1;
            exp_addr[n+1+k]  = ALIGN_EN ? addr : {addr[31:2], 2'b00};
            exp_we[n+1+k]    = wr;
            exp_wdata[n+1+k] = wd;
         end
         exp_wb[n+2+waits] = '{data: wr ? addr : rdata, tgt: pcn, regd: ridx,
                               rw: rw, pcs: br & z, mis: 1'b0, chk_data: 1'b1};
         @(posedge clk); #1;
         for (int k = 0; k <= waits; k++) begin
            junk_inputs();
            valid_in        = 1'($urandom_range(0, 1));
            mem_bus.mem_ack = (k == waits);
            if (k == waits) mem_bus.mem_rdata = rdata;
            @(posedge clk); #1;
         end
      end
      idle_inputs();
   endtask

   int          n0;
   logic [31:0] ra;
   int          kind;

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_stall", stall, 0);
      chk("rst_mem_req", mem_bus.mem_req, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_branch_target", branch_target, 0);
      @(posedge clk); #1;
      chk_en = 1'b1;

      // ALU op
      do_op(0, 0, 32'h10, 32'h0, 5'd5, 1, 0, 0, 32'h0, 32'h0, 0);
      chk("model_alu_data", exp_wb[cyc].data, 32'h10);
      @(negedge clk);
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_wb_data", wb_data, 32'h10);
      chk("alu_wb_regD", wb_regD, 5);
      @(posedge clk); #1;

      // Load with 3 wait cycles
      n0 = cyc;
      do_op(1, 0, 32'h40, 32'h0, 5'd7, 1, 0, 0, 32'h0, 32'hDEADBEEF, 3);
      chk("load_latency", cyc - n0, 5);
      chk("model_load_addr", exp_addr[n0+4], 32'h40);
      @(negedge clk);
      chk("load_wb_data", wb_data, 32'hDEADBEEF);
      @(posedge clk); #1;

      // Store with same-cycle ack
      n0 = cyc;
      do_op(0, 1, 32'h80, 32'h1234, 5'd0, 0, 0, 0, 32'h0, 32'h0, 0);
      chk("store_latency", cyc - n0, 2);
      @(negedge clk);
      chk("store_wb_valid", wb_valid, 1);
      chk("store_wb_data", wb_data, 32'h80);
      @(posedge clk); #1;

      // Branch taken / not taken
      do_op(0, 0, 32'h5, 32'h0, 5'd1, 0, 1, 1, 32'h100, 32'h0, 0);
      @(negedge clk);
      chk("br_pc_src", pc_src, 1);
      chk("br_target", branch_target, 32'h100);
      @(posedge clk); #1;
      do_op(0, 0, 32'h5, 32'h0, 5'd1, 0, 1, 0, 32'h100, 32'h0, 0);
      @(negedge clk);
      chk("br_nottaken", pc_src, 0);
      @(posedge clk); #1;

      // Read and write together: write wins
      do_op(1, 1, 32'h200, 32'hABCD, 5'd3, 0, 0, 0, 32'h0, 32'h55555555, 1);
      @(negedge clk);
      chk("rw_wb_data", wb_data, 32'h200);
      @(posedge clk); #1;

      // Misaligned load
      n0 = cyc;
      do_op(1, 0, 32'h42, 32'h0, 5'd9, 1, 0, 0, 32'h0, 32'hCAFE0000, 1);
      @(negedge clk);
      chk("mis_wb_valid", wb_valid, 1);
      chk("mis_flag", misalign, ALIGN_EN);
      chk("mis_reg_write", wb_reg_write, !ALIGN_EN);
      @(posedge clk); #1;

      // Reset while in REQ, ack one cycle later
      n0 = cyc;
      valid_in = 1'b1; regDdata = 32'h300; mem_read = 1'b1; mem_write = 1'b0;
      regD = 5'd4; reg_write = 1'b1; mem_bus.mem_ack = 1'b0;
      exp_stall[n0]  = 1'b1;
      exp_req[n0+1]  = 1'b1;
      exp_addr[n0+1] = 32'h300;
      exp_we[n0+1]   = 1'b0;
      @(posedge clk); #1;
      valid_in = 1'b0; mem_bus.mem_ack = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h77777777;
      @(negedge clk);
      chk("rstreq_mem_req", mem_bus.mem_req, 0);
      chk("rstreq_wb_valid", wb_valid, 0);
      chk("rstreq_wb_data", wb_data, 0);
      @(posedge clk); #1;
      mem_bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      gap(2);

      // Randomized operations
      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 3);
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         do_op(kind == 1 || kind == 3, kind >= 2, ra, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom_range(0, 4));
         gap($urandom_range(0, 2));
      end
      gap(3);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
